// File: rtl/cache_defs.sv
// cache_defs
//   Shared constants and types for the instruction-cache line responder:
//   default line geometry, derived index/tag widths, the NOP word returned
//   when no fetch is being acknowledged, and the responder FSM state type.
package cache_defs;

  localparam logic [31:0] INSTR_NOP_WORD = 32'h0000_0013;

  localparam int XLEN       = 32;
  localparam int LINE_WORDS = 4;
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int TAG_W      = XLEN - 2 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_RESPOND
  } type_icresp_state_e;

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store
//   One cache line: LINE_WORDS x XLEN data registers plus a valid bit and tag.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset (valid/tag only)
//     wr_en/wr_idx/wr_data  write one refill beat into the word at wr_idx
//     fill_done           last beat of a refill: tag is written, valid <= fill_keep
//     fill_keep           1 = line ends valid after the refill
//     fill_tag            tag belonging to the refilled line
//     flush               invalidate; overrides fill_done in the same edge
//     rd_idx/rd_data      combinational word read
//     valid, tag          current line state
module icache_line_store #(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = XLEN - 2 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             fill_done,
  input  logic             fill_keep,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [XLEN-1:0]  rd_data,
  output logic             valid,
  output logic [TAG_W-1:0] tag
);

  logic [XLEN-1:0]  words_reg [LINE_WORDS];
  logic             valid_reg;
  logic [TAG_W-1:0] tag_reg;

  // Data words carry no reset: they are only observed once valid is set,
  // and valid is only set after every word has been rewritten.
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          words_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
    end else begin
      if (fill_done) begin
        tag_reg <= fill_tag;
      end
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (fill_done) begin
        valid_reg <= fill_keep;
      end
    end
  end

  assign rd_data = words_reg[rd_idx];
  assign valid   = valid_reg;
  assign tag     = tag_reg;

endmodule

// File: rtl/icache_line_responder.sv
// icache_line_responder
//   Single-line instruction cache answering the prefetch stage's req/addr with
//   a one-cycle ack/r_data pulse. Misses refill the whole line base-first over
//   a word-wide memory bus (mem_req/mem_ack, data valid with mem_ack).
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     req_i, addr_i   fetch request (level, held until ack_o) and byte address
//     kill_i          pipeline clear, cancels the pending fetch
//     flush_i         invalidate the line
//     ack_o, r_data_o response pulse and fetched word (INSTR_NOP when ack_o=0)
//     mem_req_o, mem_addr_o   refill beat request and word-aligned address
//     mem_ack_i, mem_rdata_i  beat accepted and its data
module icache_line_responder #(
  parameter int              XLEN       = 32,
  parameter int              LINE_WORDS = cache_defs::LINE_WORDS,
  parameter logic [XLEN-1:0] INSTR_NOP  = XLEN'(cache_defs::INSTR_NOP_WORD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic            kill_i,
  input  logic            flush_i,
  output logic            ack_o,
  output logic [XLEN-1:0] r_data_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);
  import cache_defs::*;

  localparam int LW_IDX_W = $clog2(LINE_WORDS);
  localparam int LW_TAG_W = XLEN - 2 - LW_IDX_W;

  type_icresp_state_e     state_reg;
  logic                   ack_reg;
  logic [XLEN-1:0]        data_reg;
  logic                   mem_req_reg;
  logic [XLEN-1:0]        mem_addr_reg;
  logic [LW_IDX_W-1:0]    idx_reg;
  logic [LW_TAG_W-1:0]    tag_reg;
  logic [LW_IDX_W-1:0]    beat_reg;
  logic                   cancel_reg;
  logic                   inval_reg;

  logic [LW_TAG_W-1:0]    req_tag;
  logic [LW_IDX_W-1:0]    req_idx;
  logic [LW_IDX_W-1:0]    rd_idx;
  logic [XLEN-1:0]        rd_data;
  logic                   line_valid;
  logic [LW_TAG_W-1:0]    line_tag;
  logic                   accept;
  logic                   hit;
  logic                   beat;
  logic                   last_beat;
  logic                   cancel_now;
  logic [XLEN-1:0]        fill_word;
  logic                   unused_addr_lsb;

  assign req_tag         = addr_i[XLEN-1 -: LW_TAG_W];
  assign req_idx         = addr_i[LW_IDX_W+1:2];
  assign unused_addr_lsb = ^addr_i[1:0];

  // A request is only looked at in IDLE outside an ack cycle: while ack is
  // high the level req_i still belongs to the request being acknowledged.
  assign accept    = (state_reg == ST_IDLE) && !ack_reg && req_i && !kill_i;
  // A flush in the same cycle turns the lookup into a miss.
  assign hit       = line_valid && (line_tag == req_tag) && !flush_i;
  assign beat      = (state_reg == ST_REFILL) && mem_ack_i;
  assign last_beat = beat && (beat_reg == LW_IDX_W'(LINE_WORDS - 1));
  assign cancel_now = cancel_reg || kill_i;

  assign rd_idx = (state_reg == ST_IDLE) ? req_idx : idx_reg;

  // The final beat is still being written when the response word is latched,
  // so take it straight from the bus if it is the requested word.
  assign fill_word = (idx_reg == LW_IDX_W'(LINE_WORDS - 1)) ? mem_rdata_i : rd_data;

  icache_line_store #(
    .XLEN       (XLEN),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (LW_IDX_W),
    .TAG_W      (LW_TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (beat),
    .wr_idx    (beat_reg),
    .wr_data   (mem_rdata_i),
    .fill_done (last_beat),
    .fill_keep (!(inval_reg || flush_i)),
    .fill_tag  (tag_reg),
    .flush     (flush_i),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .valid     (line_valid),
    .tag       (line_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ack_reg      <= 1'b0;
      data_reg     <= INSTR_NOP;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      idx_reg      <= '0;
      tag_reg      <= '0;
      beat_reg     <= '0;
      cancel_reg   <= 1'b0;
      inval_reg    <= 1'b0;
    end else begin
      ack_reg  <= 1'b0;
      data_reg <= INSTR_NOP;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (hit) begin
              ack_reg  <= 1'b1;
              data_reg <= rd_data;
            end else begin
              idx_reg      <= req_idx;
              tag_reg      <= req_tag;
              beat_reg     <= '0;
              cancel_reg   <= 1'b0;
              inval_reg    <= 1'b0;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= {req_tag, {LW_IDX_W{1'b0}}, 2'b00};
              state_reg    <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          // Neither kill nor flush aborts the bus transfer; they only decide
          // whether the fetch is answered and whether the line stays valid.
          if (kill_i) begin
            cancel_reg <= 1'b1;
          end
          if (flush_i) begin
            inval_reg <= 1'b1;
          end
          if (mem_ack_i) begin
            beat_reg     <= beat_reg + LW_IDX_W'(1);
            mem_addr_reg <= mem_addr_reg + XLEN'(4);
            if (last_beat) begin
              mem_req_reg <= 1'b0;
              ack_reg     <= !cancel_now;
              data_reg    <= cancel_now ? INSTR_NOP : fill_word;
              state_reg   <= ST_RESPOND;
            end
          end
        end
        ST_RESPOND: begin
          // Ack cycle of a refill; req_i is still the acknowledged request.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // A kill landing on an ack cycle suppresses the response.
  assign ack_o      = ack_reg && !kill_i;
  assign r_data_o   = ack_o ? data_reg : INSTR_NOP;
  assign mem_req_o  = mem_req_reg;
  assign mem_addr_o = mem_addr_reg;

endmodule

// File: tb/tb_icache_line_responder.sv
// tb_icache_line_responder
//   Directed bench for icache_line_responder. Memory answers every beat in the
//   cycle it is requested; line 0x1000 holds 0xA0..0xA3, every other word holds
//   its address XOR 0x5A5A0000.
module tb_icache_line_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic [31:0] addr_i;
  logic        kill_i;
  logic        flush_i;
  logic        ack_o;
  logic [31:0] r_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] beat_addr [8];

  icache_line_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .kill_i      (kill_i),
    .flush_i     (flush_i),
    .ack_o       (ack_o),
    .r_data_o    (r_data_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack_i   = mem_req_o;
  assign mem_rdata_i = (mem_addr_o[31:4] == 28'h0000100)
                       ? (32'h0000_00A0 + {30'b0, mem_addr_o[3:2]})
                       : (mem_addr_o ^ 32'h5A5A_0000);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%h", tag, got);
    end
  endtask

  // Issue one fetch starting at the next falling edge. Cycle c is sampled at
  // the c-th falling edge after the request is raised. kill/flush are driven
  // for one cycle right after sampling cycle kill_at/flush_at (0 = never);
  // a kill also drops the request. lat = -1 when no ack was seen.
  task automatic fetch(input logic [31:0] a, input int kill_at, input int flush_at,
                       output int lat, output logic [31:0] dat, output int nbeats,
                       output logic nop_bad);
    @(negedge clk);
    addr_i  = a;
    req_i   = 1'b1;
    lat     = -1;
    dat     = '0;
    nbeats  = 0;
    nop_bad = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_req_o && mem_ack_i) begin
        if (nbeats < 8) beat_addr[nbeats] = mem_addr_o;
        nbeats++;
      end
      if (!ack_o && (r_data_o !== NOP)) nop_bad = 1'b1;
      if (ack_o) begin
        lat = c;
        dat = r_data_o;
        break;
      end
      kill_i  = (c == kill_at);
      flush_i = (c == flush_at);
      if (c == kill_at) req_i = 1'b0;
      if ((kill_at > 0) && (c >= kill_at + 8)) break;
    end
    req_i   = 1'b0;
    kill_i  = 1'b0;
    flush_i = 1'b0;
  endtask

  int          lat;
  logic [31:0] dat;
  int          nb;
  logic        nb_bad;
  int          a1, a2;
  logic [31:0] d1, d2;
  logic        prev_ack, consec, memreq_seen;

  initial begin
    rst_n   = 1'b1;
    req_i   = 1'b0;
    addr_i  = '0;
    kill_i  = 1'b0;
    flush_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ack", {31'b0, ack_o}, 32'd0);
    check_val("rst_rdata", r_data_o, NOP);
    check_val("rst_memreq", {31'b0, mem_req_o}, 32'd0);
    check_val("rst_memaddr", mem_addr_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss at 0x1000
    fetch(32'h1000, 0, 0, lat, dat, nb, nb_bad);
    check_val("miss1000_lat", 32'(lat), 32'd5);
    check_val("miss1000_data", dat, 32'h0000_00A0);
    check_val("miss1000_beats", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("miss1000_beat%0d", i), beat_addr[i], 32'h1000 + 32'(4 * i));
    check_val("miss1000_nop", {31'b0, nb_bad}, 32'd0);

    // Hit, unaligned byte address 0x100A -> word 2
    fetch(32'h100A, 0, 0, lat, dat, nb, nb_bad);
    check_val("hit100A_lat", 32'(lat), 32'd1);
    check_val("hit100A_data", dat, 32'h0000_00A2);
    check_val("hit100A_beats", 32'(nb), 32'd0);
    check_val("hit100A_nop", {31'b0, nb_bad}, 32'd0);

    // Back-to-back hits with req held: 0x1000 then 0x1004
    @(negedge clk);
    addr_i = 32'h1000;
    req_i  = 1'b1;
    a1 = -1; a2 = -1; d1 = '0; d2 = '0;
    prev_ack = 1'b0; consec = 1'b0; memreq_seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_req_o) memreq_seen = 1'b1;
      if (ack_o && prev_ack) consec = 1'b1;
      prev_ack = ack_o;
      if (ack_o) begin
        if (a1 < 0) begin
          a1 = c; d1 = r_data_o; addr_i = 32'h1004;
        end else if (a2 < 0) begin
          a2 = c; d2 = r_data_o; req_i = 1'b0;
        end
      end
    end
    req_i = 1'b0;
    check_val("b2b_ack1_cyc", 32'(a1), 32'd1);
    check_val("b2b_ack1_data", d1, 32'h0000_00A0);
    check_val("b2b_ack2_cyc", 32'(a2), 32'd3);
    check_val("b2b_ack2_data", d2, 32'h0000_00A1);
    check_val("b2b_no_consec_ack", {31'b0, consec}, 32'd0);
    check_val("b2b_no_memreq", {31'b0, memreq_seen}, 32'd0);

    // Kill during the second beat of a miss at 0x2000
    fetch(32'h2000, 2, 0, lat, dat, nb, nb_bad);
    check_val("kill2000_noack", 32'(lat), 32'hFFFF_FFFF);
    check_val("kill2000_beats", 32'(nb), 32'd4);
    fetch(32'h2004, 0, 0, lat, dat, nb, nb_bad);
    check_val("hit2004_lat", 32'(lat), 32'd1);
    check_val("hit2004_data", dat, 32'h5A5A_2004);
    check_val("hit2004_beats", 32'(nb), 32'd0);

    // Flush during the refill of line 0x3000 (fetching word 2)
    fetch(32'h3008, 0, 2, lat, dat, nb, nb_bad);
    check_val("flush3008_lat", 32'(lat), 32'd5);
    check_val("flush3008_data", dat, 32'h5A5A_3008);
    fetch(32'h3000, 0, 0, lat, dat, nb, nb_bad);
    check_val("refetch3000_beats", 32'(nb), 32'd4);
    check_val("refetch3000_lat", 32'(lat), 32'd5);
    check_val("refetch3000_data", dat, 32'h5A5A_3000);

    // Reset asserted mid-refill of 0x4000
    @(negedge clk);
    addr_i = 32'h4000;
    req_i  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("midrst_pre_memreq", {31'b0, mem_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_memreq", {31'b0, mem_req_o}, 32'd0);
    check_val("midrst_ack", {31'b0, ack_o}, 32'd0);
    check_val("midrst_rdata", r_data_o, NOP);
    req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h1000, 0, 0, lat, dat, nb, nb_bad);
    check_val("postrst_beats", 32'(nb), 32'd4);
    check_val("postrst_lat", 32'(lat), 32'd5);
    check_val("postrst_data", dat, 32'h0000_00A0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
